i2c_target: RTL

// - I2C target (slave): sole consumer of the i2c_master SCL/SDA bus. Oversamples SCL/SDA on clk.
// - Detects START/STOP and matches a 7-bit address. Drives ACK.
// - Write transactions: delivers received bytes to the core.
// - Read transactions: shifts out core-supplied bytes.
// - Open-drain via sda_oe; the pad-level tri-state lives in the top-level wrapper.

---
 rtl/i2c_pkg.sv | 18 +
 rtl/i2c_target_if.sv | 29 ++
 rtl/i2c_bus_sync.sv | 44 ++++
 rtl/i2c_target.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target and any future bus monitor.
package i2c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ADDR      = 3'd1,
    ST_ADDR_ACK  = 3'd2,
    ST_WR_DATA   = 3'd3,
    ST_WR_ACK    = 3'd4,
    ST_RD_DATA   = 3'd5,
    ST_RD_ACK    = 3'd6,
    ST_WAIT_STOP = 3'd7
  } i2c_tgt_state_e;

  localparam logic I2C_RW_READ = 1'b1;
  localparam logic I2C_ACK     = 1'b0;

endpackage

// File: rtl/i2c_target_if.sv
// Bus-side and core-side signals of the I2C target, plus its FSM state for observation.
interface i2c_target_if;
  import i2c_pkg::*;

  // Pin levels in, open-drain enable out; tx_req/rx_valid are single-cycle
  // strobes with no ready: the core must present tx_data before the load edge
  // and must consume rx_data on the cycle rx_valid is high.
  logic           scl_in;
  logic           sda_in;
  logic           sda_oe;
  logic [7:0]     tx_data;
  logic           tx_req;
  logic [7:0]     rx_data;
  logic           rx_valid;
  logic           addr_match;
  logic           busy;
  i2c_tgt_state_e state;

  modport slave (
    input  scl_in, sda_in, tx_data,
    output sda_oe, tx_req, rx_data, rx_valid, addr_match, busy, state
  );

  modport master (
    output scl_in, sda_in, tx_data,
    input  sda_oe, tx_req, rx_data, rx_valid, addr_match, busy, state
  );

endinterface

// File: rtl/i2c_bus_sync.sv
// SCL/SDA synchronisers with edge, START and STOP detection on the synchronised levels.
module i2c_bus_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic scl_i,
  input  logic sda_i,
  output logic scl_o,
  output logic sda_o,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_o,
  output logic stop_o
);

  logic [SYNC_STAGES-1:0] scl_sync_q;
  logic [SYNC_STAGES-1:0] sda_sync_q;
  logic                   scl_prev_q;
  logic                   sda_prev_q;

  // Reset to the idle-bus level so leaving reset never looks like an edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
      scl_prev_q <= scl_sync_q[SYNC_STAGES-1];
      sda_prev_q <= sda_sync_q[SYNC_STAGES-1];
    end
  end

  assign scl_o      = scl_sync_q[SYNC_STAGES-1];
  assign sda_o      = sda_sync_q[SYNC_STAGES-1];
  assign scl_rise_o = scl_o & ~scl_prev_q;
  assign scl_fall_o = ~scl_o & scl_prev_q;
  assign start_o    = scl_o & scl_prev_q & sda_prev_q & ~sda_o;
  assign stop_o     = scl_o & scl_prev_q & ~sda_prev_q & sda_o;

endmodule

// File: rtl/i2c_target.sv
// I2C target: address match, ACK generation, write-byte delivery and read-byte shifting.
module i2c_target
  import i2c_pkg::*;
#(
  parameter logic [6:0] TARGET_ADDR = 7'h55,
  parameter int         SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         reset,
  i2c_target_if.slave  bus
);

  logic scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det;
  logic bit_rise, bit_fall;

  i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk        (clk),
    .reset      (reset),
    .scl_i      (bus.scl_in),
    .sda_i      (bus.sda_in),
    .scl_o      (scl_s),
    .sda_o      (sda_s),
    .scl_rise_o (scl_rise),
    .scl_fall_o (scl_fall),
    .start_o    (start_det),
    .stop_o     (stop_det)
  );

  assign bit_rise = scl_rise & scl_s;
  assign bit_fall = scl_fall & ~scl_s;

  i2c_tgt_state_e state_q;
  logic [2:0]     bit_cnt_q;
  logic [7:0]     shreg_q;
  logic           rw_q;
  logic           sda_oe_q;
  logic           tx_req_q;
  logic [7:0]     rx_data_q;
  logic           rx_valid_q;
  logic           addr_match_q;
  logic           busy_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      bit_cnt_q    <= 3'd0;
      shreg_q      <= 8'h00;
      rw_q         <= 1'b0;
      sda_oe_q     <= 1'b0;
      tx_req_q     <= 1'b0;
      rx_data_q    <= 8'h00;
      rx_valid_q   <= 1'b0;
      addr_match_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      tx_req_q   <= 1'b0;
      rx_valid_q <= 1'b0;
      if (start_det) begin
        state_q      <= ST_ADDR;
        bit_cnt_q    <= 3'd0;
        sda_oe_q     <= 1'b0;
        busy_q       <= 1'b1;
        addr_match_q <= 1'b0;
      end else if (stop_det) begin
        state_q      <= ST_IDLE;
        sda_oe_q     <= 1'b0;
        busy_q       <= 1'b0;
        addr_match_q <= 1'b0;
      end else begin
        case (state_q)
          ST_ADDR: begin
            if (bit_rise) begin
              shreg_q   <= {shreg_q[6:0], sda_s};
              bit_cnt_q <= bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) begin
                if (shreg_q[6:0] == TARGET_ADDR) begin
                  rw_q    <= sda_s;
                  state_q <= ST_ADDR_ACK;
                end else begin
                  state_q <= ST_WAIT_STOP;
                end
              end
            end
          end
          // First fall opens the ACK slot, the second closes it.
          ST_ADDR_ACK: begin
            if (bit_rise) begin
              addr_match_q <= 1'b1;
              if (rw_q == I2C_RW_READ) tx_req_q <= 1'b1;
            end else if (bit_fall) begin
              if (!sda_oe_q) begin
                sda_oe_q <= 1'b1;
              end else if (rw_q == I2C_RW_READ) begin
                shreg_q   <= bus.tx_data;
                sda_oe_q  <= ~bus.tx_data[7];
                bit_cnt_q <= 3'd0;
                state_q   <= ST_RD_DATA;
              end else begin
                sda_oe_q <= 1'b0;
                state_q  <= ST_WR_DATA;
              end
            end
          end
          ST_WR_DATA: begin
            if (bit_rise) begin
              shreg_q   <= {shreg_q[6:0], sda_s};
              bit_cnt_q <= bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) begin
                rx_data_q  <= {shreg_q[6:0], sda_s};
                rx_valid_q <= 1'b1;
                state_q    <= ST_WR_ACK;
              end
            end
          end
          ST_WR_ACK: begin
            if (bit_fall) begin
              if (!sda_oe_q) begin
                sda_oe_q <= 1'b1;
              end else begin
                sda_oe_q <= 1'b0;
                state_q  <= ST_WR_DATA;
              end
            end
          end
          // bit_cnt counts rises; it wraps to 0 after the 8th bit has been clocked.
          ST_RD_DATA: begin
            if (bit_rise) begin
              bit_cnt_q <= bit_cnt_q + 3'd1;
            end else if (bit_fall) begin
              if (bit_cnt_q == 3'd0) begin
                sda_oe_q <= 1'b0;
                state_q  <= ST_RD_ACK;
              end else begin
                sda_oe_q <= ~shreg_q[6];
                shreg_q  <= {shreg_q[6:0], 1'b0};
              end
            end
          end
          ST_RD_ACK: begin
            if (bit_rise) begin
              if (sda_s == I2C_ACK) tx_req_q <= 1'b1;
              else                  state_q  <= ST_WAIT_STOP;
            end else if (bit_fall) begin
              shreg_q   <= bus.tx_data;
              sda_oe_q  <= ~bus.tx_data[7];
              bit_cnt_q <= 3'd0;
              state_q   <= ST_RD_DATA;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.sda_oe     = sda_oe_q;
  assign bus.tx_req     = tx_req_q;
  assign bus.rx_data    = rx_data_q;
  assign bus.rx_valid   = rx_valid_q;
  assign bus.addr_match = addr_match_q;
  assign bus.busy       = busy_q;
  assign bus.state      = state_q;

endmodule
